muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the MULT and DIV operations (ALU control codes 4'b0010 and 4'b0011), which the single-cycle ALU cannot complete in one cycle.
- Accepts a start request from the execute stage and runs a 32-iteration signed shift-add multiply or restoring divide.
- Writes results into the HI/LO register pair.
- Holds busy so the pipeline stalls on mfhi/mflo or a new mult/div until the result is ready.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITERS, WIDTH, iteration count per operation; fixed equal to WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- alu_ctr  input  4  ALU control code. 4'b0010 = MULT, 4'b0011 = DIV; other codes make start ignored.
- op_a  input  WIDTH  rs operand (multiplicand / dividend), two's complement.
- op_b  input  WIDTH  rt operand (multiplier / divisor), two's complement.
- abort  input  1  pipeline flush; cancels the operation in flight.
- wr_hi  input  1  mthi write strobe.
- wr_lo  input  1  mtlo write strobe.
- wr_data  input  WIDTH  data for mthi/mtlo.
- busy  output  1  high while an operation is in progress (stall request).
- done  output  1  one-cycle pulse when HI/LO have just been updated.
- div0  output  1  sticky flag: last DIV had a zero divisor; cleared by the next accepted start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; busy=0, done=0, div0=0, hi=0, lo=0; internal registers cleared. Reset overrides every other input, including mid-operation.
- States: IDLE, ITER, FIX.
- IDLE:
  - start=1 with a valid alu_ctr (cycle N): latch |op_a|, |op_b|, result sign, remainder sign and op type; clear the counter; clear div0; go to ITER.
  - DIV with op_b==0: go directly to FIX with the div0 path selected.
  - start with an invalid alu_ctr: ignored, state stays IDLE.
- ITER, MULT: each cycle, if multiplier LSB=1, add multiplicand to the upper half of the 2*WIDTH accumulator; shift right 1.
- ITER, DIV: each cycle, shift the remainder:quotient pair left 1; trial-subtract the divisor; keep the result and set the quotient LSB if non-negative.
- ITER counter: 0..ITERS-1. Exit to FIX after the cycle with count==ITERS-1, giving 32 ITER cycles (N+1..N+32).
- FIX (1 cycle), sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the dividend's sign.
  - hi/lo load at the end of FIX; done=1 in the following cycle; state returns to IDLE.
- Latency:
  - Normal: busy=1 in N+1..N+33; done=1 and new hi/lo visible in N+34; busy=0 in N+34.
  - Div-by-zero: busy=1 in N+1 (FIX only); done=1 in N+2 with lo=all ones, hi=op_a, div0=1.
- Result mapping: MULT gives {hi,lo} = 64-bit signed product. DIV gives lo = quotient (truncated toward zero) and hi = remainder.
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (low 32 bits of the magnitude result); no trap.
- start while busy: ignored (the pipeline must stall on busy; no queueing).
- abort while in ITER or FIX: next state IDLE, busy=0, no done, hi/lo unchanged. abort in IDLE has no effect; abort with start in the same IDLE cycle drops the start.
- wr_hi/wr_lo:
  - Applied only in IDLE, when not accepting a start.
  - Ignored while busy.
  - Accepted start together with a write in the same cycle: start wins and the write is dropped.
  - wr_hi and wr_lo together: both registers get wr_data.
- done is never high together with busy. hi/lo change only on FIX completion, mthi/mtlo, or reset.

Decomposition:
- Package muldiv_pkg:
  - ALUCTR_MULT=4'b0010 and ALUCTR_DIV=4'b0011 (must match the ALU control encoding).
  - State enum {IDLE, ITER, FIX}.
  - Op-type enum {OP_MUL, OP_DIV}.
- One natural sub-module, muldiv_iter: the combinational single-step add/shift or subtract/shift datapath. The FSM, counter, sign logic and HI/LO stay in muldiv_sequencer.

Test Plan:
- MULT 7 × -3 (op_a=7, op_b=0xFFFFFFFD) at cycle N -> busy N+1..N+33; done at N+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done at N+34, div0=0.
- DIV 100 / 0 -> done at N+2, lo=0xFFFFFFFF, hi=100, div0=1. Next accepted MULT 0x80000000 × 0x80000000 -> div0 cleared; hi=0x40000000, lo=0.
- MULT started, abort asserted at N+10 -> busy=0 at N+11, no done pulse, hi/lo keep their prior values. start re-pulsed during busy has no effect.
- wr_hi=1, wr_data=0x1234 in IDLE -> hi=0x1234 next cycle. wr_lo with start (DIV 0x80000000/0xFFFFFFFF) in the same cycle -> write dropped; result lo=0x80000000, hi=0.
- rst asserted at N+20 of a DIV -> next cycle all outputs 0, state IDLE; a new start is accepted the cycle after rst deasserts.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multi-cycle MULT/DIV sequencer.
package muldiv_pkg;

    // ALU control codes routed to the sequencer; must track the ALU decoder.
    localparam logic [3:0] ALUCTR_MULT = 4'b0010;
    localparam logic [3:0] ALUCTR_DIV  = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_t;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> sequencer bundle: start request, mthi/mtlo writes, HI/LO and status.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_ctr;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             abort;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, alu_ctr, op_a, op_b, abort, wr_hi, wr_lo, wr_data,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, alu_ctr, op_a, op_b, abort, wr_hi, wr_lo, wr_data,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/muldiv_iter.sv
// One combinational step of unsigned shift-add multiply or restoring divide.
// acc_i holds {upper, lower}: MULT = {partial product, multiplier},
// DIV = {remainder, dividend/quotient}. opnd_i is the multiplicand or divisor.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  op_t                op_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // Add-then-shift keeps the carry as the new accumulator MSB; the divide
    // trial subtraction borrow (trial MSB) decides restore vs keep.
    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        trial  = rem_sh - {1'b0, opnd_i};
        if (op_i == OP_MUL) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO. Operands are reduced to
// magnitudes on accept, iterated unsigned, and sign-corrected in FIX.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITERS = WIDTH
) (
    input logic    clk,
    input logic    rst,
    muldiv_if.slave bus
);

    localparam int unsigned CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               div0_q, div0_d;

    logic               a_neg, b_neg, is_div, valid_ctr, accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_step;

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .op_i   (op_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_step)
    );

    // Operand decode for the accept cycle.
    always_comb begin
        a_neg     = bus.op_a[WIDTH-1];
        b_neg     = bus.op_b[WIDTH-1];
        a_mag     = cond_neg(a_neg, bus.op_a);
        b_mag     = cond_neg(b_neg, bus.op_b);
        is_div    = (bus.alu_ctr == ALUCTR_DIV);
        valid_ctr = (bus.alu_ctr == ALUCTR_MULT) || is_div;
        accept    = (state_q == IDLE) && bus.start && valid_ctr && !bus.abort;
    end

    // Next-state, datapath and HI/LO update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        div0_d    = div0_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = is_div ? OP_DIV : OP_MUL;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    div0_d    = 1'b0;
                    opnd_d    = is_div ? b_mag : a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                    dz_d      = is_div && (bus.op_b == '0);
                    state_d   = (is_div && (bus.op_b == '0)) ? FIX : ITER;
                end else begin
                    if (bus.wr_hi) hi_d = bus.wr_data;
                    if (bus.wr_lo) lo_d = bus.wr_data;
                end
            end
            ITER: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.abort) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        // acc low half still holds |dividend|; restoring its sign gives op_a back.
                        lo_d   = '1;
                        hi_d   = cond_neg(neg_rem_q, acc_q[WIDTH-1:0]);
                        div0_d = 1'b1;
                    end else if (op_q == OP_MUL) begin
                        {hi_d, lo_d} = neg_res_q ? (~acc_q + 1'b1) : acc_q;
                    end else begin
                        lo_d = cond_neg(neg_res_q, acc_q[WIDTH-1:0]);
                        hi_d = cond_neg(neg_rem_q, acc_q[2*WIDTH-1:WIDTH]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes reference results,
// a monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    exp_t        sb_q[$];
    exp_t        last_exp;
    exp_t        mon_e;
    logic [31:0] m_hi, m_lo;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W), .ITERS(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference from plain signed arithmetic; due = cycle done must be seen.
    function automatic exp_t ref_model(input logic [3:0] ctr, input logic [31:0] a,
                                       input logic [31:0] b, input int unsigned drive_cyc);
        exp_t        e;
        longint      sa, sb, p, q, r;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.div0 = 1'b0;
        e.due  = drive_cyc + 34;
        if (ctr == ALUCTR_MULT) begin
            p = sa * sb;
            v = p;
            e.hi = v[63:32];
            e.lo = v[31:0];
        end else if (b == 32'd0) begin
            e.hi   = a;
            e.lo   = 32'hFFFFFFFF;
            e.div0 = 1'b1;
            e.due  = drive_cyc + 2;
        end else begin
            q = sa / sb;
            r = sa % sb;
            v = q;
            e.lo = v[31:0];
            v = r;
            e.hi = v[31:0];
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            check("busy_with_done", {63'd0, bus.busy}, 64'd0);
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got done=1, expected no pending result (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("res_hi", {32'd0, bus.hi}, {32'd0, mon_e.hi});
                check("res_lo", {32'd0, bus.lo}, {32'd0, mon_e.lo});
                check("res_div0", {63'd0, bus.div0}, {63'd0, mon_e.div0});
                check("done_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.alu_ctr = 4'd0;
        bus.op_a    = '0;
        bus.op_b    = '0;
        bus.abort   = 1'b0;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        bus.wr_data = '0;
    endtask

    // Called just after a negedge; returns at the first busy cycle.
    task automatic issue(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int unsigned k);
        if (push) begin
            last_exp = ref_model(ctr, a, b, cyc);
            sb_q.push_back(last_exp);
        end
        bus.start   = 1'b1;
        bus.alu_ctr = ctr;
        bus.op_a    = a;
        bus.op_b    = b;
        @(negedge clk);
        bus.start = 1'b0;
        k = cyc;
    endtask

    task automatic finish_op(input bit update_model);
        int unsigned n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            total_cnt++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles, expected busy=0", n);
        end
        if (update_model) begin
            m_hi = last_exp.hi;
            m_lo = last_exp.lo;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned k;
        int unsigned kind, j;
        logic [31:0] a, b, d;
        logic [3:0]  ctr;
        bit          wh, wl;

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_div0", {63'd0, bus.div0}, 64'd0);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);

        // MULT 7 x -3 with busy window and a write attempted mid-operation
        issue(ALUCTR_MULT, 32'd7, 32'hFFFFFFFD, 1'b1, k);
        check("t1_busy_first", {63'd0, bus.busy}, 64'd1);
        while (cyc < k + 5) @(negedge clk);
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'hDEAD;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        check("wr_while_busy", {32'd0, bus.hi}, {32'd0, m_hi});
        while (cyc < k + 32) @(negedge clk);
        check("t1_busy_last", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
        check("t1_busy_clear", {63'd0, bus.busy}, 64'd0);
        finish_op(1'b1);

        // DIV -7 / 2
        issue(ALUCTR_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, k);
        finish_op(1'b1);

        // DIV 100 / 0, sticky div0, then MULT clears it
        issue(ALUCTR_DIV, 32'd100, 32'd0, 1'b1, k);
        check("dz_busy", {63'd0, bus.busy}, 64'd1);
        finish_op(1'b1);
        repeat (3) @(negedge clk);
        check("div0_sticky", {63'd0, bus.div0}, 64'd1);
        issue(ALUCTR_MULT, 32'h80000000, 32'h80000000, 1'b1, k);
        check("div0_cleared", {63'd0, bus.div0}, 64'd0);
        finish_op(1'b1);

        // Abort at N+10 with a start re-pulse while busy
        issue(ALUCTR_MULT, 32'd12345, 32'd678, 1'b0, k);
        while (cyc < k + 3) @(negedge clk);
        bus.start   = 1'b1;
        bus.alu_ctr = ALUCTR_DIV;
        bus.op_a    = 32'd50;
        bus.op_b    = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < k + 9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("abort_hi", {32'd0, bus.hi}, {32'd0, m_hi});
        check("abort_lo", {32'd0, bus.lo}, {32'd0, m_lo});

        // Abort together with start in IDLE drops the start; invalid ctr ignored
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        bus.alu_ctr = ALUCTR_MULT;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_idle_start", {63'd0, bus.busy}, 64'd0);
        bus.alu_ctr = 4'b0110;
        @(negedge clk);
        bus.start = 1'b0;
        check("invalid_ctr", {63'd0, bus.busy}, 64'd0);

        // mthi, then mthi+mtlo together
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'h1234;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        m_hi = 32'h1234;
        check("mthi", {32'd0, bus.hi}, {32'd0, m_hi});
        check("mthi_lo_kept", {32'd0, bus.lo}, {32'd0, m_lo});
        bus.wr_hi   = 1'b1;
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'hA5A5_0F0F;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        m_hi = 32'hA5A5_0F0F;
        m_lo = 32'hA5A5_0F0F;
        check("mthi_mtlo_hi", {32'd0, bus.hi}, {32'd0, m_hi});
        check("mthi_mtlo_lo", {32'd0, bus.lo}, {32'd0, m_lo});

        // mtlo in the accept cycle is dropped; overflow divide
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'hCAFE;
        issue(ALUCTR_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, k);
        bus.wr_lo = 1'b0;
        check("start_wins_lo", {32'd0, bus.lo}, {32'd0, m_lo});
        finish_op(1'b1);

        // Reset in the middle of a DIV
        issue(ALUCTR_DIV, 32'd1000, 32'd7, 1'b0, k);
        while (cyc < k + 19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        check("midrst_div0", {63'd0, bus.div0}, 64'd0);
        check("midrst_hi", {32'd0, bus.hi}, 64'd0);
        check("midrst_lo", {32'd0, bus.lo}, 64'd0);
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        issue(ALUCTR_MULT, 32'hFFFFFFFB, 32'd9, 1'b1, k);
        check("post_rst_accept", {63'd0, bus.busy}, 64'd1);
        finish_op(1'b1);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            a    = rand_operand();
            b    = rand_operand();
            if (kind <= 3) begin
                issue(ALUCTR_MULT, a, b, 1'b1, k);
                finish_op(1'b1);
            end else if (kind <= 6) begin
                issue(ALUCTR_DIV, a, b, 1'b1, k);
                finish_op(1'b1);
            end else if (kind == 7) begin
                ctr = 4'($urandom_range(4, 15));
                bus.start   = 1'b1;
                bus.alu_ctr = ctr;
                @(negedge clk);
                bus.start = 1'b0;
                check("rnd_invalid_busy", {63'd0, bus.busy}, 64'd0);
            end else if (kind == 8) begin
                wh = 1'($urandom_range(0, 1));
                wl = 1'($urandom_range(0, 1));
                d  = $urandom;
                bus.wr_hi   = wh;
                bus.wr_lo   = wl;
                bus.wr_data = d;
                @(negedge clk);
                bus.wr_hi = 1'b0;
                bus.wr_lo = 1'b0;
                if (wh) m_hi = d;
                if (wl) m_lo = d;
                check("rnd_wr_hi", {32'd0, bus.hi}, {32'd0, m_hi});
                check("rnd_wr_lo", {32'd0, bus.lo}, {32'd0, m_lo});
            end else begin
                if (b == 32'd0) b = 32'd1;
                ctr = ($urandom_range(0, 1) != 0) ? ALUCTR_DIV : ALUCTR_MULT;
                issue(ctr, a, b, 1'b0, k);
                j = $urandom_range(0, 32);
                repeat (j) @(negedge clk);
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                check("rnd_abort_busy", {63'd0, bus.busy}, 64'd0);
                @(negedge clk);
                check("rnd_abort_hi", {32'd0, bus.hi}, {32'd0, m_hi});
                check("rnd_abort_lo", {32'd0, bus.lo}, {32'd0, m_lo});
            end
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
